// File: rtl/con3_pkg.sv
// Shared constants, FSM state type and sizing helpers for the CON3 servo link.
package con3_pkg;

    localparam int STEP_NS         = 3910;
    localparam int STEPS_PER_FRAME = 256;

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH,
        DONE
    } dec_state_e;

    function automatic int step_limit(input int clk_period_ns);
        return STEP_NS / clk_period_ns;
    endfunction

    function automatic int presc_width(input int limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

    function automatic int step_cnt_width(input int high_cycle, input int low_cycle,
                                          input int timeout_frames);
        return $clog2((high_cycle + low_cycle + 1) * STEPS_PER_FRAME * timeout_frames + 1);
    endfunction

endpackage

// File: rtl/servo_in_conditioner.sv
// Synchronizes the asynchronous servo line, optionally deglitches it
// (SERVO_DECODER_GLITCH_FILTER_EN) and produces registered rise/fall strobes.
module servo_in_conditioner (
    input  logic clk,
    input  logic rst,
    input  logic servo_in,
    output logic line,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic rise_q,  rise_d;
    logic fall_q,  fall_d;
    logic line_in;

`ifdef SERVO_DECODER_GLITCH_FILTER_EN
    logic       filt_q, filt_d;
    logic [1:0] glitch_cnt_q, glitch_cnt_d;

    // The filtered level flips only on the 4th consecutive differing sample.
    always_comb begin
        filt_d       = filt_q;
        glitch_cnt_d = 2'd0;
        if (sync2_q != filt_q) begin
            if (glitch_cnt_q == 2'd3) begin
                filt_d = sync2_q;
            end else begin
                glitch_cnt_d = glitch_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_q       <= 1'b1;
            glitch_cnt_q <= 2'd0;
        end else begin
            filt_q       <= filt_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign line_in = filt_q;
`else
    assign line_in = sync2_q;
`endif

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        sync1_d = servo_in;
        sync2_d = sync1_q;
        prev_d  = line_in;
        rise_d  = line_in & ~prev_q;
        fall_d  = ~line_in & prev_q;
    end

    // NOTE: the line pipeline resets to 1 so a line already high at reset release
    // never looks like a fresh rising edge; only a real low-to-high transition counts.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign line = prev_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// CON3 servo PWM receiver: measures pulse high time in 3.91 us steps and recovers
// the 8-bit angle. Optional deglitching via SERVO_DECODER_GLITCH_FILTER_EN.
module servo_pwm_decoder
    import con3_pkg::*;
#(
    parameter int CLK_PERIOD     = 10,
    parameter int HIGH_CYCLE     = 1,
    parameter int LOW_CYCLE      = 2,
    parameter int TIMEOUT_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       servo_in,
    output logic [7:0] angle,
    output logic       angle_valid,
    output logic       range_err,
    output logic       signal_ok
);

    localparam int STEP_LIMIT = step_limit(CLK_PERIOD);
    localparam int PRESC_W    = presc_width(STEP_LIMIT);
    localparam int CNT_W      = step_cnt_width(HIGH_CYCLE, LOW_CYCLE, TIMEOUT_FRAMES);
    localparam int WIDTH_W    = CNT_W + 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST    = PRESC_W'(STEP_LIMIT - 1);
    localparam logic [PRESC_W-1:0] PRESC_HALF    = PRESC_W'(STEP_LIMIT / 2);
    localparam logic [CNT_W-1:0]   CNT_MAX       = '1;
    localparam logic [CNT_W-1:0]   TIMEOUT_STEPS =
        CNT_W'((HIGH_CYCLE + LOW_CYCLE + 1) * STEPS_PER_FRAME * TIMEOUT_FRAMES);
    localparam logic [CNT_W-1:0]   STUCK_STEPS   = CNT_W'((HIGH_CYCLE + 1) * STEPS_PER_FRAME + 8);
    localparam logic [WIDTH_W-1:0] HIGH_STEPS    = WIDTH_W'(HIGH_CYCLE * STEPS_PER_FRAME);
    localparam logic [WIDTH_W-1:0] RAW_MAX       = WIDTH_W'(255);

    logic srst_n;
    logic line, rise, fall;

    dec_state_e         state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [7:0]         angle_q, angle_d;
    logic               angle_valid_q, angle_valid_d;
    logic               range_err_q, range_err_d;
    logic               signal_ok_q, signal_ok_d;

    logic [PRESC_W-1:0] presc_next;
    logic [CNT_W-1:0]   step_cnt_next;
    logic [WIDTH_W-1:0] raw;

    // Disabling the block is indistinguishable from reset, down to the synchronizer.
    assign srst_n = rst & en;

    servo_in_conditioner u_cond (
        .clk      (clk),
        .rst      (srst_n),
        .servo_in (servo_in),
        .line     (line),
        .rise     (rise),
        .fall     (fall)
    );

    always_comb begin
        presc_next    = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
        step_cnt_next = step_cnt_q;
        if (presc_q == PRESC_LAST && step_cnt_q != CNT_MAX) begin
            step_cnt_next = step_cnt_q + CNT_W'(1);
        end
        raw = width_q - HIGH_STEPS;
    end

    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        step_cnt_d    = step_cnt_q;
        width_d       = width_q;
        angle_d       = angle_q;
        angle_valid_d = 1'b0;
        range_err_d   = 1'b0;
        signal_ok_d   = signal_ok_q;

        unique case (state_q)
            WAIT_LOW: begin
                presc_d    = '0;
                step_cnt_d = '0;
                if (!line) begin
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    presc_d    = '0;
                    step_cnt_d = '0;
                    state_d    = HIGH;
                end else begin
                    presc_d    = presc_next;
                    step_cnt_d = step_cnt_next;
                    if (step_cnt_q >= TIMEOUT_STEPS) begin
                        signal_ok_d = 1'b0;
                    end
                end
            end
            HIGH: begin
                if (fall) begin
                    // Round to the nearest step using the partial prescaler count.
                    width_d = {1'b0, step_cnt_q} + WIDTH_W'(presc_q >= PRESC_HALF);
                    state_d = DONE;
                end else if (step_cnt_q > STUCK_STEPS) begin
                    range_err_d = 1'b1;
                    signal_ok_d = 1'b0;
                    state_d     = WAIT_LOW;
                end else begin
                    presc_d    = presc_next;
                    step_cnt_d = step_cnt_next;
                end
            end
            DONE: begin
                if (width_q < HIGH_STEPS) begin
                    angle_d     = 8'd0;
                    range_err_d = 1'b1;
                end else if (raw > RAW_MAX) begin
                    angle_d     = 8'd255;
                    range_err_d = 1'b1;
                end else begin
                    angle_d = raw[7:0];
                end
                angle_valid_d = 1'b1;
                signal_ok_d   = 1'b1;
                presc_d       = '0;
                step_cnt_d    = '0;
                state_d       = WAIT_RISE;
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q       <= WAIT_LOW;
            presc_q       <= '0;
            step_cnt_q    <= '0;
            width_q       <= '0;
            angle_q       <= 8'd0;
            angle_valid_q <= 1'b0;
            range_err_q   <= 1'b0;
            signal_ok_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            step_cnt_q    <= step_cnt_d;
            width_q       <= width_d;
            angle_q       <= angle_d;
            angle_valid_q <= angle_valid_d;
            range_err_q   <= range_err_d;
            signal_ok_q   <= signal_ok_d;
        end
    end

    assign angle       = angle_q;
    assign angle_valid = angle_valid_q;
    assign range_err   = range_err_q;
    assign signal_ok   = signal_ok_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder; runs with a 2-clk step so full
// frames stay short. Expected angles come from hand-computed step counts.
module tb_servo_pwm_decoder;

    localparam int CLK_PERIOD_P = 1955;   // 3910/1955 = 2 clk per step
    localparam int CPS          = 2;
`ifdef SERVO_DECODER_GLITCH_FILTER_EN
    localparam int LAT  = 8;
    localparam bit GLIT = 1'b1;
`else
    localparam int LAT  = 4;
    localparam bit GLIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       servo_in = 1'b1;
    logic [7:0] angle;
    logic       angle_valid;
    logic       range_err;
    logic       signal_ok;

    int checks   = 0;
    int failures = 0;

    servo_pwm_decoder #(
        .CLK_PERIOD     (CLK_PERIOD_P),
        .HIGH_CYCLE     (1),
        .LOW_CYCLE      (2),
        .TIMEOUT_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .servo_in    (servo_in),
        .angle       (angle),
        .angle_valid (angle_valid),
        .range_err   (range_err),
        .signal_ok   (signal_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Count strobes over a bounded window of n cycles.
    task automatic watch(input int n, output int valid_cnt, output int err_cnt);
        valid_cnt = 0;
        err_cnt   = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (angle_valid === 1'b1) valid_cnt++;
            if (range_err === 1'b1) err_cnt++;
        end
    endtask

    // High for `steps` steps (optionally with a 2-clk low glitch mid-pulse),
    // then low; reports latency from the falling edge to angle_valid.
    task automatic send_pulse(input int steps, input bit glitch,
                              output int lat, output int valid_cnt,
                              output int err_cnt, output int ok_at_valid);
        int h1;
        lat = -1;
        ok_at_valid = -1;
        valid_cnt = 0;
        err_cnt = 0;
        @(negedge clk) servo_in = 1'b1;
        if (glitch) begin
            h1 = (steps * CPS) / 2;
            idle(h1);
            servo_in = 1'b0;
            idle(2);
            servo_in = 1'b1;
            idle(steps * CPS - h1 - 2);
        end else begin
            idle(steps * CPS);
        end
        servo_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (angle_valid === 1'b1) begin
                valid_cnt++;
                if (lat < 0) begin
                    lat = i;
                    ok_at_valid = int'(signal_ok);
                end
            end
            if (range_err === 1'b1) err_cnt++;
        end
    endtask

    initial begin
        int lat, vc, ec, ok;

        // Reset held with the line high, as if mid-pulse.
        idle(3);
        check("rst_angle", int'(angle), 0);
        check("rst_valid", int'(angle_valid), 0);
        check("rst_err", int'(range_err), 0);
        check("rst_ok", int'(signal_ok), 0);

        // Release reset mid-pulse: the partial pulse must be ignored.
        rst = 1'b1;
        idle(200);
        servo_in = 1'b0;
        watch(40, vc, ec);
        check("partial_no_valid", vc, 0);
        idle(100);

        send_pulse(300, 1'b0, lat, vc, ec, ok);
        check("p300_angle", int'(angle), 44);
        check("p300_valid_cnt", vc, 1);
        check("p300_err", ec, 0);
        idle(1000);

        send_pulse(384, 1'b0, lat, vc, ec, ok);
        check("p384_angle", int'(angle), 128);
        check("p384_latency", lat, LAT);
        check("p384_valid_cnt", vc, 1);
        check("p384_err", ec, 0);
        check("p384_ok", ok, 1);
        idle(50);
        check("p384_angle_hold", int'(angle), 128);
        check("p384_valid_low", int'(angle_valid), 0);
        idle(1000);

        send_pulse(256, 1'b0, lat, vc, ec, ok);
        check("p256_angle", int'(angle), 0);
        check("p256_err", ec, 0);
        idle(1000);

        send_pulse(511, 1'b0, lat, vc, ec, ok);
        check("p511_angle", int'(angle), 255);
        check("p511_err", ec, 0);
        idle(1000);

        send_pulse(520, 1'b0, lat, vc, ec, ok);
        check("p520_angle", int'(angle), 255);
        check("p520_err", ec, 1);
        check("p520_ok", ok, 1);

        // Line idles low past 2048 steps: signal loss.
        idle(3900);
        check("timeout_before", int'(signal_ok), 1);
        idle(400);
        check("timeout_after", int'(signal_ok), 0);
        send_pulse(384, 1'b0, lat, vc, ec, ok);
        check("recover_angle", int'(angle), 128);
        check("recover_ok", ok, 1);
        idle(1000);

        // Line stuck high for 600 steps.
        servo_in = 1'b1;
        watch(1200, vc, ec);
        check("stuck_no_valid", vc, 0);
        check("stuck_err", ec, 1);
        check("stuck_ok", int'(signal_ok), 0);
        servo_in = 1'b0;
        watch(40, vc, ec);
        check("stuck_fall_no_valid", vc, 0);
        idle(100);
        send_pulse(300, 1'b0, lat, vc, ec, ok);
        check("stuck_recover_angle", int'(angle), 44);
        check("stuck_recover_ok", ok, 1);
        idle(500);

        // en dropped mid-pulse: measurement discarded, block restarts.
        servo_in = 1'b1;
        idle(200);
        en = 1'b0;
        idle(3);
        check("en_off_ok", int'(signal_ok), 0);
        check("en_off_angle", int'(angle), 0);
        en = 1'b1;
        idle(200);
        servo_in = 1'b0;
        watch(40, vc, ec);
        check("en_partial_no_valid", vc, 0);
        idle(100);
        send_pulse(384, 1'b0, lat, vc, ec, ok);
        check("en_recover_angle", int'(angle), 128);

        // CON3-style frames at angle 200: 456 high, 568 low steps.
        idle(2 * 568 - 30);
        for (int f = 0; f < 2; f++) begin
            send_pulse(456, GLIT, lat, vc, ec, ok);
            check("loop_range", int'(angle >= 8'd199 && angle <= 8'd201), 1);
            check("loop_valid_cnt", vc, 1);
            idle(2 * 568 - 30);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
